vga_timing_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 36 +++
 rtl/wrap_counter.sv | 41 ++++
 rtl/vga_timing_gen.sv | 175 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA raster definitions.
//   - coord_t: pixel coordinate type shared by the timing generator and
//     every downstream renderer.
//   - Default 640x480 @ 60 Hz timing constants and the totals / sync
//     windows derived from them.
//   - COORD_LIMIT: largest total a 10-bit coordinate counter can cover.
package vga_pkg;

  typedef logic [9:0] coord_t;

  // Default horizontal timing, in pixel clocks.
  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;

  // Default vertical timing, in lines.
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  // Derived totals and sync windows; each window is [START, END).
  localparam int unsigned DEF_H_TOTAL  = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned DEF_V_TOTAL  = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int unsigned DEF_HS_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int unsigned DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
  localparam int unsigned DEF_VS_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int unsigned DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

  // A coord_t counter can count 0..1023, so totals may not exceed 1024.
  localparam int unsigned COORD_LIMIT = 1024;

  localparam int unsigned DEF_FRAME_CNT_W = 16;

endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: modulo-N up-counter with enable.
//   Ports:
//     clk    in   clock
//     rst_n  in   asynchronous active-low reset (count -> 0)
//     en     in   advance the count on this clock
//     count  out  W   current count, 0..N-1
//     wrap   out  1   combinational: en is high and count is N-1, so the
//                     count returns to 0 on the next clock
//   No handshake: the counter free-runs whenever en is high.
module wrap_counter #(
  parameter int unsigned N = 800,
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);
  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

  if ((N < 1) || (N > (1 << W))) begin : g_bad_modulus
    $error("wrap_counter: modulus N does not fit in W bits");
  end

  logic at_last;

  assign at_last = (count == LAST);
  assign wrap    = en && at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= at_last ? '0 : (count + ONE);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster timing generator.
//   Ports:
//     vga_clk      in   pixel clock (25 MHz nominal for 640x480 @ 60 Hz)
//     reset_n      in   asynchronous active-low reset
//     hs           out  horizontal sync, active low
//     vs           out  vertical sync, active low
//     blank        out  1 = visible pixel, 0 = blanking interval
//     DrawX        out  presented pixel column, 0..H_TOTAL-1
//     DrawY        out  presented pixel row,    0..V_TOTAL-1
//     line_start   out  one-clock pulse while DrawX == 0
//     frame_start  out  one-clock pulse while DrawX == 0 and DrawY == 0
//     frame_count  out  completed-frame counter (wraps modulo 2^FRAME_CNT_W)
//   There is no input handshake: the raster free-runs out of reset.
//
// hc/vc are the position that will be presented on the next clock. Every
// output is registered from the same hc/vc, so all of them describe one
// pixel and lag the counters by exactly one clock.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE   = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT     = DEF_H_FRONT,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_BACK      = DEF_H_BACK,
  parameter int unsigned V_VISIBLE   = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT     = DEF_V_FRONT,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_BACK      = DEF_V_BACK,
  parameter int unsigned FRAME_CNT_W = DEF_FRAME_CNT_W
) (
  input  logic                   vga_clk,
  input  logic                   reset_n,
  output logic                   hs,
  output logic                   vs,
  output logic                   blank,
  output coord_t                 DrawX,
  output coord_t                 DrawY,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  // Totals and sync windows for this instance's timing.
  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  if (H_TOTAL > COORD_LIMIT) begin : g_h_too_big
    $error("vga_timing_gen: H_TOTAL exceeds the 10-bit coordinate range");
  end
  if (V_TOTAL > COORD_LIMIT) begin : g_v_too_big
    $error("vga_timing_gen: V_TOTAL exceeds the 10-bit coordinate range");
  end
  if (FRAME_CNT_W < 1) begin : g_fc_too_small
    $error("vga_timing_gen: FRAME_CNT_W must be at least 1");
  end

  // Window limits may equal 1024 (one past the largest coordinate), so
  // the decodes compare in 11 bits to keep every bound representable.
  localparam logic [10:0] H_VIS_X    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS_X    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START_X = 11'(HS_START);
  localparam logic [10:0] HS_END_X   = 11'(HS_END);
  localparam logic [10:0] VS_START_X = 11'(VS_START);
  localparam logic [10:0] VS_END_X   = 11'(VS_END);

  localparam logic [FRAME_CNT_W-1:0] FC_ONE = {{(FRAME_CNT_W-1){1'b0}}, 1'b1};

  // Raster counters: next position to present.
  coord_t hc;
  coord_t vc;
  logic   h_wrap;
  logic   v_wrap;

  wrap_counter #(
    .N (H_TOTAL),
    .W (10)
  ) u_h_counter (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .en    (1'b1),
    .count (hc),
    .wrap  (h_wrap)
  );

  // The line counter only steps when the pixel counter wraps.
  wrap_counter #(
    .N (V_TOTAL),
    .W (10)
  ) u_v_counter (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .en    (h_wrap),
    .count (vc),
    .wrap  (v_wrap)
  );

  // Decodes of the position about to be presented.
  logic [10:0] hc_x;
  logic [10:0] vc_x;
  logic        blank_d;
  logic        hs_d;
  logic        vs_d;
  logic        line_start_d;
  logic        frame_start_d;

  assign hc_x = {1'b0, hc};
  assign vc_x = {1'b0, vc};

  always_comb begin
    blank_d       = 1'b0;
    hs_d          = 1'b1;
    vs_d          = 1'b1;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    blank_d = (hc_x < H_VIS_X) && (vc_x < V_VIS_X);
    if ((hc_x >= HS_START_X) && (hc_x < HS_END_X)) begin
      hs_d = 1'b0;
    end
    // vc only changes together with hc returning to 0, so vs moves on
    // the same presented pixel as DrawX returning to 0.
    if ((vc_x >= VS_START_X) && (vc_x < VS_END_X)) begin
      vs_d = 1'b0;
    end
    line_start_d  = (hc == '0);
    frame_start_d = (hc == '0) && (vc == '0);
  end

  // Set once the raster has run through its last pixel since reset. The
  // frame_start that follows a completed frame bumps frame_count; the
  // very first frame_start after reset has no completed frame behind it
  // and leaves the count at 0.
  logic frame_completed;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_completed <= 1'b0;
    end else if (v_wrap) begin
      frame_completed <= 1'b1;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank       <= 1'b0;
      DrawX       <= '0;
      DrawY       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hs          <= hs_d;
      vs          <= vs_d;
      blank       <= blank_d;
      DrawX       <= hc;
      DrawY       <= vc;
      line_start  <= line_start_d;
      frame_start <= frame_start_d;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= '0;
    end else if (frame_start_d && frame_completed) begin
      frame_count <= frame_count + FC_ONE;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one instance with the default 640x480 timing
// and one with a tiny raster and a 2-bit frame counter, sharing clock and
// reset. Expected outputs come from the pixel index since reset release.
module tb_vga_timing_gen;
  import vga_pkg::*;

  // Small raster: 20 clocks per line, 13 lines, 260 clocks per frame.
  localparam int S_HV = 10, S_HF = 3, S_HS = 4, S_HB = 3;
  localparam int S_VV = 6,  S_VF = 2, S_VS = 2, S_VB = 3;

  // Packed view: {hs, vs, blank, line_start, frame_start, x, y, fc16}.
  localparam logic [40:0] RST_VAL   = {5'b11000, 10'd0, 10'd0, 16'd0};
  localparam logic [40:0] START_VAL = {5'b11111, 10'd0, 10'd0, 16'd0};

  // ---------------- clock / reset ----------------
  logic vga_clk = 1'b0;
  logic reset_n = 1'b1;
  always #20 vga_clk = ~vga_clk;

  // ---------------- DUTs ----------------
  logic        hs_b, vs_b, blank_b, ls_b, fs_b;
  coord_t      x_b, y_b;
  logic [15:0] fc_b;
  logic        hs_s, vs_s, blank_s, ls_s, fs_s;
  coord_t      x_s, y_s;
  logic [1:0]  fc_s;

  vga_timing_gen dut_big (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .hs          (hs_b),
    .vs          (vs_b),
    .blank       (blank_b),
    .DrawX       (x_b),
    .DrawY       (y_b),
    .line_start  (ls_b),
    .frame_start (fs_b),
    .frame_count (fc_b)
  );

  vga_timing_gen #(
    .H_VISIBLE (S_HV), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
    .V_VISIBLE (S_VV), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB),
    .FRAME_CNT_W (2)
  ) dut_small (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .hs          (hs_s),
    .vs          (vs_s),
    .blank       (blank_s),
    .DrawX       (x_s),
    .DrawY       (y_s),
    .line_start  (ls_s),
    .frame_start (fs_s),
    .frame_count (fc_s)
  );

  logic [40:0] got_b, got_s;
  assign got_b = {hs_b, vs_b, blank_b, ls_b, fs_b, x_b, y_b, fc_b};
  assign got_s = {hs_s, vs_s, blank_s, ls_s, fs_s, x_s, y_s, 14'd0, fc_s};

  // ---------------- model ----------------
  // t = number of clock edges since reset release; edge t presents pixel
  // index t-1 of an endless raster.
  longint t = 0;
  always @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) t <= 0;
    else          t <= t + 1;
  end

  function automatic logic [40:0] model(input int hv, hf, hsy, hb,
                                        input int vv, vf, vsy, vb,
                                        input int fw, input longint tt);
    longint p, ht, vt, x, y, f, fc;
    logic hs_e, vs_e, bl_e, ls_e, fs_e;
    if (tt == 0) return RST_VAL;
    ht = hv + hf + hsy + hb;
    vt = vv + vf + vsy + vb;
    p  = tt - 1;
    x  = p % ht;
    y  = (p / ht) % vt;
    f  = p / (ht * vt);
    fc = f % (longint'(1) << fw);
    hs_e = !((x >= hv + hf) && (x < hv + hf + hsy));
    vs_e = !((y >= vv + vf) && (y < vv + vf + vsy));
    bl_e = (x < hv) && (y < vv);
    ls_e = (x == 0);
    fs_e = (x == 0) && (y == 0);
    return {hs_e, vs_e, bl_e, ls_e, fs_e, 10'(x), 10'(y), 16'(fc)};
  endfunction

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check_vec(input string name, input logic [40:0] got, input logic [40:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0d got hs,vs,bl,ls,fs=%b x=%0d y=%0d fc=%0d want hs,vs,bl,ls,fs=%b x=%0d y=%0d fc=%0d",
               name, t, got[40:36], got[35:26], got[25:16], got[15:0],
               want[40:36], want[35:26], want[25:16], want[15:0]);
    end
  endtask

  task automatic check_int(input string name, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s t=%0d got=%0d want=%0d", name, t, got, want);
    end
  endtask

  logic run_cmp = 1'b0;

  // Per-cycle comparison of both instances against the model.
  always @(negedge vga_clk) begin
    if (run_cmp) begin
      check_vec("big_cycle", got_b, model(640, 16, 96, 48, 480, 10, 2, 33, 16, t));
      check_vec("small_cycle", got_s, model(S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, 2, t));
    end
  end

  // Small-raster frame statistics over the first frames after reset,
  // including the 2-bit frame_count wrap sequence.
  logic [1:0] exp_q[$];
  longint     last_fs   = -1;
  int         vs_low    = 0;
  int         blank_cnt = 0;

  always @(negedge vga_clk) begin
    if (run_cmp) begin
      if (fs_s && (exp_q.size() > 0)) begin
        check_int("fc_seq", fc_s, exp_q.pop_front());
        if (last_fs >= 0) begin
          check_int("frame_period", t - last_fs, 260);
          check_int("vs_low_per_frame", vs_low, 40);
          check_int("blank_per_frame", blank_cnt, 60);
        end
        last_fs   = t;
        vs_low    = 0;
        blank_cnt = 0;
      end
      if (!vs_s)   vs_low++;
      if (blank_s) blank_cnt++;
    end
  end

  // ---------------- driver ----------------
  task automatic pulse_reset(input int off_lo, input int off_hi, input int hold);
    #(off_lo) reset_n = 1'b0;
    #1;
    check_vec("async_rst_big", got_b, RST_VAL);
    check_vec("async_rst_small", got_s, RST_VAL);
    repeat (hold) @(negedge vga_clk);
    #(off_hi) reset_n = 1'b1;
  endtask

  initial begin
    int hs_low, first_hs, blank_hi, found, n;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    #5 reset_n = 1'b0;
    #1;
    check_vec("por_big", got_b, RST_VAL);
    check_vec("por_small", got_s, RST_VAL);
    run_cmp = 1'b1;
    repeat (3) @(negedge vga_clk);
    #5 reset_n = 1'b1;

    @(negedge vga_clk);
    check_vec("first_pixel_big", got_b, START_VAL);
    check_vec("first_pixel_small", got_s, START_VAL);

    // First line of the default raster.
    hs_low = 0; first_hs = -1; blank_hi = 0;
    for (int i = 0; i < 800; i++) begin
      if (!hs_b) begin
        if (first_hs < 0) first_hs = int'(x_b);
        hs_low++;
      end
      if (blank_b) blank_hi++;
      if (i < 799) @(negedge vga_clk);
    end
    check_int("hs_low_clocks", hs_low, 96);
    check_int("hs_first_x", first_hs, 656);
    check_int("blank_per_line", blank_hi, 640);
    @(negedge vga_clk);
    check_int("line_wrap_x", x_b, 0);
    check_int("line_wrap_y", y_b, 1);
    check_int("line_wrap_ls", ls_b, 1);

    // Reset in the middle of a frame.
    found = 0;
    for (int i = 0; (i < 20000) && (found == 0); i++) begin
      @(negedge vga_clk);
      if ((x_b == 10'd300) && (y_b == 10'd20)) found = 1;
    end
    check_int("reach_mid_frame", found, 1);
    pulse_reset(5, 5, 2);
    @(negedge vga_clk);
    check_vec("restart_big", got_b, START_VAL);
    check_vec("restart_small", got_s, START_VAL);

    // Randomly placed resets of random length.
    repeat (4) begin
      n = $urandom_range(3000, 100);
      repeat (n) @(negedge vga_clk);
      pulse_reset($urandom_range(14, 2), $urandom_range(14, 2), $urandom_range(3, 1));
    end

    repeat (12000) @(negedge vga_clk);
    run_cmp = 1'b0;
    check_int("fc_seq_consumed", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
